keypad_matrix_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 17 +
 rtl/key_event_fifo.sv | 59 +++++
 rtl/keypad_matrix_scanner.sv | 178 +++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner and its event FIFO.
package keypad_pkg;

  localparam logic EVT_PRESS   = 1'b0;
  localparam logic EVT_RELEASE = 1'b1;

  typedef enum logic [1:0] {
    NONE,
    ONE,
    MULTI
  } frame_res_e;

  function automatic int unsigned code_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead event queue with count-based full/empty; a push that cannot land is reported on drop_o.
module key_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    pop     = !empty && ready_i;
    // a full queue still accepts a push when the head leaves in the same cycle
    wr_en   = push_i && (!full || pop);
    drop_o  = push_i && full && !pop;
    valid_o = !empty;
    data_o  = empty ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanned keypad: per-frame ghost rejection, frame debounce, press/release events into a FIFO.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 30000,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter bit          EMIT_RELEASE    = 1'b1,
  localparam int unsigned CODE_W         = code_w(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [COLS-1:0]   col_drive,
  input  logic [ROWS-1:0]   row_sense,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              key_held,
  output logic [CODE_W-1:0] held_code,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int unsigned TW  = $clog2(SCAN_DIV);
  localparam int unsigned CIW = $clog2(COLS);

  logic [TW-1:0]     tick_q, tick_d;
  logic              tick;
  logic [ROWS-1:0]   rs_meta_q, rs_sync_q;
  logic [COLS-1:0]   col_drive_q, col_drive_d;
  logic [CIW-1:0]    col_q, col_d;
  frame_res_e        acc_q, acc_d, res;
  logic [CODE_W-1:0] acc_code_q, acc_code_d, res_code;
  logic              frame_end;
  logic              cand_key_q, cand_key_d;
  logic [CODE_W-1:0] cand_code_q, cand_code_d;
  logic [3:0]        db_cnt_q, db_cnt_d;
  logic              stab_key_q, stab_key_d;
  logic [CODE_W-1:0] stab_code_q, stab_code_d;
  logic              cand_differs;
  logic              chg_q, chg_d;
  logic              held_q, held_d;
  logic [CODE_W-1:0] held_code_q, held_code_d;
  logic              overflow_q, overflow_d;
  logic              push;
  logic              drop;
  logic [CODE_W:0]   push_data;
  logic [CODE_W:0]   head;

  always_comb begin
    tick        = (tick_q == TW'(SCAN_DIV - 1));
    tick_d      = tick ? '0 : tick_q + 1'b1;
    frame_end   = tick && (col_q == CIW'(COLS - 1));
    col_drive_d = col_drive_q;
    col_d       = col_q;
    acc_d       = acc_q;
    acc_code_d  = acc_code_q;

    // fold this column's rows into the running frame result
    res      = acc_q;
    res_code = acc_code_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (rs_sync_q[r]) begin
        if (res == NONE) begin
          res      = ONE;
          res_code = CODE_W'(r * COLS + 32'(col_q));
        end else begin
          res = MULTI;
        end
      end
    end

    if (tick) begin
      col_drive_d = {col_drive_q[COLS-2:0], col_drive_q[COLS-1]};
      col_d       = frame_end ? '0 : col_q + 1'b1;
      acc_d       = frame_end ? NONE : res;
      acc_code_d  = frame_end ? '0 : res_code;
    end

    cand_key_d  = cand_key_q;
    cand_code_d = cand_code_q;
    db_cnt_d    = db_cnt_q;
    if (frame_end && res != MULTI) begin
      if (((res == ONE) == cand_key_q) && (res == NONE || res_code == cand_code_q)) begin
        if (db_cnt_q != 4'(DEBOUNCE_FRAMES)) db_cnt_d = db_cnt_q + 1'b1;
      end else begin
        cand_key_d  = (res == ONE);
        cand_code_d = (res == ONE) ? res_code : '0;
        db_cnt_d    = 4'd1;
      end
    end

    cand_differs = (cand_key_q != stab_key_q) || (cand_key_q && cand_code_q != stab_code_q);
    stab_key_d   = stab_key_q;
    stab_code_d  = stab_code_q;
    chg_d        = 1'b0;
    if (db_cnt_q == 4'(DEBOUNCE_FRAMES) && cand_differs) begin
      stab_key_d  = cand_key_q;
      stab_code_d = cand_code_q;
      chg_d       = 1'b1;
    end

    // a release reports the key that was held; A->B reports only the press of B
    push      = chg_q && (stab_key_q || EMIT_RELEASE);
    push_data = {stab_key_q ? EVT_PRESS : EVT_RELEASE, stab_key_q ? stab_code_q : held_code_q};
    held_d      = held_q;
    held_code_d = held_code_q;
    if (chg_q) begin
      held_d = stab_key_q;
      if (stab_key_q) held_code_d = stab_code_q;
    end

    overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q      <= '0;
      rs_meta_q   <= '0;
      rs_sync_q   <= '0;
      col_drive_q <= COLS'(1);
      col_q       <= '0;
      acc_q       <= NONE;
      acc_code_q  <= '0;
      cand_key_q  <= 1'b0;
      cand_code_q <= '0;
      db_cnt_q    <= '0;
      stab_key_q  <= 1'b0;
      stab_code_q <= '0;
      chg_q       <= 1'b0;
      held_q      <= 1'b0;
      held_code_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      rs_meta_q   <= row_sense;
      rs_sync_q   <= rs_meta_q;
      col_drive_q <= col_drive_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      cand_key_q  <= cand_key_d;
      cand_code_q <= cand_code_d;
      db_cnt_q    <= db_cnt_d;
      stab_key_q  <= stab_key_d;
      stab_code_q <= stab_code_d;
      chg_q       <= chg_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      overflow_q  <= overflow_d;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .ready_i (key_ready),
    .valid_o (key_valid),
    .data_o  (head),
    .drop_o  (drop)
  );

  assign col_drive   = col_drive_q;
  assign key_release = head[CODE_W];
  assign key_code    = head[CODE_W-1:0];
  assign key_held    = held_q;
  assign held_code   = held_code_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench: two scanners (with/without release events) share one 4x4 key matrix model.
module tb_keypad_matrix_scanner;

  typedef struct packed {
    logic       rel;
    logic [3:0] code;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys;

  logic [3:0] col1, col2, rows1, rows2, code1, code2, hcode1, hcode2;
  logic       valid1, valid2, ready1, ready2, rel1, rel2;
  logic       held1, held2, ovf1, ovf2, clr1, clr2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  ev_t q1[$];
  ev_t q2[$];

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4), .EMIT_RELEASE(1'b1)
  ) dut (
    .clk(clk), .reset(rst_n), .col_drive(col1), .row_sense(rows1),
    .key_valid(valid1), .key_ready(ready1), .key_code(code1), .key_release(rel1),
    .key_held(held1), .held_code(hcode1), .overflow(ovf1), .clr_overflow(clr1)
  );

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4), .EMIT_RELEASE(1'b0)
  ) dut_norel (
    .clk(clk), .reset(rst_n), .col_drive(col2), .row_sense(rows2),
    .key_valid(valid2), .key_ready(ready2), .key_code(code2), .key_release(rel2),
    .key_held(held2), .held_code(hcode2), .overflow(ovf2), .clr_overflow(clr2)
  );

  // key r*4+c connects row r to column c
  always_comb begin
    rows1 = '0;
    rows2 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && col1[c]) rows1[r] = 1'b1;
        if (keys[r*4+c] && col2[c]) rows2[r] = 1'b1;
      end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n) begin
      if (valid1 && ready1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev1_unexpected: got code %0d rel %0d expected no event", code1, rel1);
        end else begin
          e = q1.pop_front();
          chk("ev1_code", 32'(code1), 32'(e.code));
          chk("ev1_release", 32'(rel1), 32'(e.rel));
        end
      end
      if (valid2 && ready2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev2_unexpected: got code %0d rel %0d expected no event", code2, rel2);
        end else begin
          e = q2.pop_front();
          chk("ev2_code", 32'(code2), 32'(e.code));
          chk("ev2_release", 32'(rel2), 32'(e.rel));
        end
      end
    end
  end

  // return just after the edge where col_drive wraps back to column 0
  task automatic align();
    int unsigned n = 0;
    do begin @(posedge clk); #1; n++; end while (col1 != 4'b1000 && n < 64);
    do begin @(posedge clk); #1; n++; end while (col1 != 4'b0001 && n < 64);
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL align: got col_drive %b expected wrap to 0001", col1);
    end
  endtask

  task automatic wait_frames(input int unsigned n);
    repeat (n * 16) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n;
    int codes[5] = '{1, 2, 4, 6, 7};
    rst_n  = 1'b0;
    keys   = '0;
    ready1 = 1'b1;
    ready2 = 1'b1;
    clr1   = 1'b0;
    clr2   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_drive", 32'(col1), 1);
    chk("rst_key_valid", 32'(valid1), 0);
    chk("rst_key_code", 32'(code1), 0);
    chk("rst_key_release", 32'(rel1), 0);
    chk("rst_key_held", 32'(held1), 0);
    chk("rst_held_code", 32'(hcode1), 0);
    chk("rst_overflow", 32'(ovf1), 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("col_step", 32'(col1), 32'(1 << (i % 4)));
      repeat (4) @(posedge clk);
      #1;
    end

    // press row 2 / col 1 at a frame start: visible at the 2nd frame-end + 2 clk
    align();
    keys = 16'h0200;
    q1.push_back({1'b0, 4'd9});
    q2.push_back({1'b0, 4'd9});
    n = 0;
    while (!valid1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("press_latency", n, 34);
    wait_frames(3);
    chk("press_key_held", 32'(held1), 1);
    chk("press_held_code", 32'(hcode1), 9);
    chk("norel_press_held", 32'(held2), 1);

    align();
    keys = '0;
    q1.push_back({1'b1, 4'd9});
    wait_frames(4);
    chk("release_key_held", 32'(held1), 0);
    chk("release_held_code", 32'(hcode1), 9);
    chk("norel_release_held", 32'(held2), 0);

    // code 3 present for exactly one frame
    align();
    keys = 16'h0008;
    repeat (16) @(posedge clk);
    #1;
    keys = '0;
    wait_frames(4);
    chk("glitch_key_held", 32'(held1), 0);

    align();
    keys = 16'h0021;
    wait_frames(4);
    chk("ghost_key_held", 32'(held1), 0);
    align();
    keys = 16'h0001;
    q1.push_back({1'b0, 4'd0});
    q2.push_back({1'b0, 4'd0});
    wait_frames(4);
    chk("ghost_lift_held", 32'(held1), 1);
    chk("ghost_lift_code", 32'(hcode1), 0);

    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      align();
      keys = 16'(1) << codes[i];
      if (i < 4) q1.push_back({1'b0, 4'(codes[i])});
      q2.push_back({1'b0, 4'(codes[i])});
      wait_frames(4);
      if (i == 3) chk("full_no_overflow", 32'(ovf1), 0);
    end
    chk("overflow_set", 32'(ovf1), 1);
    chk("norel_no_overflow", 32'(ovf2), 0);
    chk("held_tracks_dropped", 32'(hcode1), 7);
    ready1 = 1'b1;
    n = 0;
    while (q1.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_bounded", 32'(n < 20), 1);
    chk("drained_valid", 32'(valid1), 0);
    chk("empty_key_code", 32'(code1), 0);
    chk("overflow_sticky", 32'(ovf1), 1);
    clr1 = 1'b1;
    @(posedge clk);
    #1;
    clr1 = 1'b0;
    chk("overflow_cleared", 32'(ovf1), 0);

    ready1 = 1'b0;
    align();
    keys = '0;
    q1.push_back({1'b1, 4'd7});
    wait_frames(4);
    align();
    keys = 16'h0004;
    q1.push_back({1'b0, 4'd2});
    q2.push_back({1'b0, 4'd2});
    wait_frames(4);
    chk("two_queued_valid", 32'(valid1), 1);
    chk("two_queued_head", 32'(code1), 7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("midrst_key_valid", 32'(valid1), 0);
    chk("midrst_col_drive", 32'(col1), 1);
    chk("midrst_key_held", 32'(held1), 0);
    keys = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ready1 = 1'b1;
    wait_frames(4);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
